// File: rtl/count_window_ctrl_pkg.sv
// Shared state encoding and default sizing for the gated-count window controller.
package count_ctrl_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int WIN_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GATE    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

endpackage

// File: rtl/count_window_ctrl_win_timer.sv
// Loadable down-counter shared by the gate window and the settle interval.
// Load wins over decrement; the count never wraps below zero.
module win_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] cnt;

  // Load a new interval or count down towards zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == W'(1));

endmodule

// File: rtl/count_window_ctrl.sv
// Measurement sequencer for the external toggle-flop event counter.
// Optional feature macro: CNT_OVF_EN (adds res_ovf and saturates res_data on wrap).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start with no result pending
// ST_CLEAR   | one cycle of cnt_clr; window length already in the timer
// ST_GATE    | cnt_en high, one cycle per programmed window count
// ST_SETTLE  | gate closed, letting the ripple counter settle
// ST_CAPTURE | sample cnt_val into res_data and raise res_valid
module count_window_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             cnt_en,
  output logic             cnt_clr,
  input  logic [CNT_W-1:0] cnt_val,
  output logic [CNT_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready
`ifdef CNT_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC);

  state_t           state;
  logic             accept;
  logic             tmr_load;
  logic [WIN_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             tmr_one;

`ifdef CNT_OVF_EN
  logic msb_q;
  logic ovf_seen;
`endif

  // A pending result blocks new requests, including the cycle it is handed off.
  assign accept = (state == ST_IDLE) && start && !res_valid;

  // Timer control: window length on accept, settle length when the gate ends.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load     = 1'b1;
          tmr_load_val = win_len;
        end
      end
      ST_CLEAR: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = SETTLE_LOAD;
        end
      end
      ST_GATE: begin
        if (tmr_one) begin
          tmr_load     = 1'b1;
          tmr_load_val = SETTLE_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  win_timer #(
    .W(WIN_W)
  ) u_win_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .is_zero  (tmr_zero),
    .is_one   (tmr_one)
  );

  // Sequencer with registered counter controls, capture and result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          cnt_en  <= 1'b0;
          cnt_clr <= 1'b0;
          if (accept) begin
            state   <= ST_CLEAR;
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_clr <= 1'b0;
          if (tmr_zero) begin
            state <= ST_SETTLE;
          end else begin
            state  <= ST_GATE;
            cnt_en <= 1'b1;
          end
        end
        ST_GATE: begin
          if (tmr_one) begin
            state  <= ST_SETTLE;
            cnt_en <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tmr_one) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
`ifdef CNT_OVF_EN
          res_data <= ovf_seen ? {CNT_W{1'b1}} : cnt_val;
`else
          res_data <= cnt_val;
`endif
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          cnt_en  <= 1'b0;
          cnt_clr <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CNT_OVF_EN
  // Watch the counter MSB fall while counting or settling; that fall means a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      msb_q    <= 1'b0;
      ovf_seen <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          msb_q    <= 1'b0;
          ovf_seen <= 1'b0;
        end
        ST_GATE, ST_SETTLE: begin
          msb_q <= cnt_val[CNT_W-1];
          if (msb_q && !cnt_val[CNT_W-1]) begin
            ovf_seen <= 1'b1;
          end
        end
        ST_CAPTURE: res_ovf <= ovf_seen;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_count_window_ctrl.sv
// Directed bench for count_window_ctrl paired with a behavioural 8-bit counter
// that sees an event every cycle. Build with CNT_OVF_EN to cover the wrap flag.
module tb_count_window_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] win_len;
  logic        busy;
  logic        cnt_en;
  logic        cnt_clr;
  logic [7:0]  cnt_val;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
`ifdef CNT_OVF_EN
  logic        res_ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  count_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .win_len   (win_len),
    .busy      (busy),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .cnt_val   (cnt_val),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
`ifdef CNT_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  // behavioural event counter, one event per cycle
  logic [7:0] ev_cnt;
  always @(posedge clk) begin
    if (cnt_clr)     ev_cnt <= 8'd0;
    else if (cnt_en) ev_cnt <= ev_cnt + 8'd1;
  end
  assign cnt_val = ev_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called in cycle 1 after the accepting edge; returns the cycle res_valid
  // is first seen (0 on timeout) and the number of cnt_en cycles
  task automatic wait_res(input int chg_cyc, input logic [15:0] chg_val,
                          output int lat, output int en_cyc);
    lat    = 0;
    en_cyc = 0;
    for (int c = 1; c < 1000; c++) begin
      if (c == chg_cyc) win_len = chg_val;
      if (res_valid) begin
        lat = c;
        break;
      end
      if (cnt_en) en_cyc++;
      tick();
    end
  endtask

  task automatic run_meas(input logic [15:0] wl, output int lat, output int en_cyc);
    start   = 1'b1;
    win_len = wl;
    tick();
    start = 1'b0;
    wait_res(0, 16'd0, lat, en_cyc);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat, en_cyc;
    logic saw_busy, saw_valid, data_moved;

    reset     = 1'b1;
    start     = 1'b0;
    win_len   = 16'd0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_cnt_clr",   cnt_clr,   1);
    chk("rst_cnt_en",    cnt_en,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data",  res_data,  0);
`ifdef CNT_OVF_EN
    chk("rst_res_ovf",   res_ovf,   0);
`endif
    reset = 1'b0;
    tick();
    tick();
    chk("idle_cnt_clr", cnt_clr, 0);

    // 1: 10-cycle window
    start   = 1'b1;
    win_len = 16'd10;
    tick();
    start = 1'b0;
    chk("t1_busy_c1", busy, 1);
    chk("t1_clr_c1",  cnt_clr, 1);
    wait_res(0, 16'd0, lat, en_cyc);
    chk("t1_lat",  lat,      15);
    chk("t1_en",   en_cyc,   10);
    chk("t1_data", res_data, 10);
    chk("t1_busy_done", busy, 0);
    handshake();
    chk("t1_valid_clr", res_valid, 0);

    // 2: zero-length window
    run_meas(16'd0, lat, en_cyc);
    chk("t2_lat",  lat,      5);
    chk("t2_en",   en_cyc,   0);
    chk("t2_data", res_data, 0);
    handshake();

    // 3: result held back, start pulses ignored
    run_meas(16'd5, lat, en_cyc);
    chk("t3_lat",  lat,      10);
    chk("t3_data", res_data, 5);
    saw_busy   = 1'b0;
    data_moved = 1'b0;
    win_len    = 16'd3;
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
      if (busy) saw_busy = 1'b1;
      if (res_data != 8'd5) data_moved = 1'b1;
    end
    chk("t3_no_busy",    saw_busy,   0);
    chk("t3_data_held",  data_moved, 0);
    chk("t3_valid_held", res_valid,  1);
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t3_hs_no_accept", busy,      0);
    chk("t3_hs_valid",     res_valid, 0);
    tick();
    start = 1'b0;
    chk("t3_accept", busy, 1);
    wait_res(0, 16'd0, lat, en_cyc);
    chk("t3b_lat",  lat,      8);
    chk("t3b_data", res_data, 3);
    handshake();

    // 4: reset mid-gate
    run_meas_start: begin
      start   = 1'b1;
      win_len = 16'd20;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
    end
    chk("t4_in_gate", cnt_en, 1);
    reset = 1'b1;
    tick();
    chk("t4_cnt_en",  cnt_en,  0);
    chk("t4_cnt_clr", cnt_clr, 1);
    chk("t4_busy",    busy,    0);
    reset     = 1'b0;
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) saw_valid = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    chk("t4_no_result", saw_valid, 0);
    chk("t4_no_busy",   saw_busy,  0);

    // 5: 300-cycle window wraps the 8-bit counter
    run_meas(16'd300, lat, en_cyc);
    chk("t5_lat", lat,    305);
    chk("t5_en",  en_cyc, 300);
`ifdef CNT_OVF_EN
    chk("t5_ovf",  res_ovf,  1);
    chk("t5_data", res_data, 8'hFF);
`else
    chk("t5_data", res_data, 8'h2C);
`endif
    handshake();

`ifdef CNT_OVF_EN
    run_meas(16'd12, lat, en_cyc);
    chk("t5_ovf_clr",  res_ovf,  0);
    chk("t5_data_raw", res_data, 12);
    handshake();
`endif

    // 6: win_len changed mid-gate, start held for back-to-back requests
    start   = 1'b1;
    win_len = 16'd7;
    tick();
    wait_res(4, 16'd2, lat, en_cyc);
    chk("t6a_lat",  lat,      12);
    chk("t6a_en",   en_cyc,   7);
    chk("t6a_data", res_data, 7);
    handshake();
    chk("t6_hs_idle", busy, 0);
    tick();
    start = 1'b0;
    chk("t6b_accept", busy, 1);
    wait_res(0, 16'd0, lat, en_cyc);
    chk("t6b_lat",  lat,      7);
    chk("t6b_en",   en_cyc,   2);
    chk("t6b_data", res_data, 2);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
